// File: rtl/instr_mem_loader_if.sv
// ----------------------------------------------------------------------------
// instr_mem_loader_if
// Bundles the byte-stream handshake, the load control/status lines and the
// instruction-memory debug write port used by instr_mem_loader.
//
//   start / load_len           : load request and instruction count
//   byte_valid / byte_data     : byte stream from the boot/test source
//   byte_ready                 : loader accepts a byte this cycle
//   dbg_wr_en/dbg_addr/dbg_instr : instruction-memory debug write port
//   cpu_rst, busy, done        : core reset and load progress status
//   len_err, checksum_err      : error flags of the last load request
//
// modport master : byte source / controller side (drives requests and bytes)
// modport slave  : the loader itself
// ----------------------------------------------------------------------------
interface instr_mem_loader_if #(
   parameter int XLEN               = 64,
   parameter int INSTRUCTION_LENGTH = XLEN / 2
);
   logic                          start;
   logic [15:0]                   load_len;
   logic                          byte_valid;
   logic [7:0]                    byte_data;
   logic                          byte_ready;
   logic                          dbg_wr_en;
   logic [XLEN-1:0]               dbg_addr;
   logic [INSTRUCTION_LENGTH-1:0] dbg_instr;
   logic                          cpu_rst;
   logic                          busy;
   logic                          done;
   logic                          len_err;
   logic                          checksum_err;

   modport master (
      output start, load_len, byte_valid, byte_data,
      input  byte_ready, dbg_wr_en, dbg_addr, dbg_instr,
      input  cpu_rst, busy, done, len_err, checksum_err
   );

   modport slave (
      input  start, load_len, byte_valid, byte_data,
      output byte_ready, dbg_wr_en, dbg_addr, dbg_instr,
      output cpu_rst, busy, done, len_err, checksum_err
   );
endinterface

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
// Receives a little-endian byte stream, assembles instructions of
// INSTRUCTION_LENGTH bits and writes each one through the instruction
// memory's debug port at consecutive word addresses starting at BASE_ADDR.
// The core is held in reset (cpu_rst) until a load has completed.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_mem_loader_if.slave (request, byte stream, debug write
//           port, status flags)
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN
//   When defined, one trailer byte follows the payload and is compared with
//   the modulo-256 sum of all payload bytes; a mismatch sets checksum_err.
//   When undefined, the CHECK state and sum register do not exist and
//   checksum_err is tied low.
// ----------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int              XLEN               = 64,
   parameter int              INSTRUCTION_LENGTH = XLEN / 2,
   parameter logic [XLEN-1:0] BASE_ADDR          = '0,
   parameter int              MAX_WORDS          = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_mem_loader_if.slave   bus
);

   localparam int BPI = INSTRUCTION_LENGTH / 8;
   localparam int CW  = $clog2(BPI + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE
   } state_t;

   state_t                        r_state;
   state_t                        w_nextState;
   logic [15:0]                   r_len;
   logic [15:0]                   r_index;
   logic [CW-1:0]                 r_byteCnt;
   logic [INSTRUCTION_LENGTH-1:0] r_buf;
   logic                          r_lenErr;
   logic                          r_csErr;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]                    r_sum;
`endif

   logic                          w_canStart;
   logic                          w_lenTooBig;
   logic                          w_startOk;
   logic                          w_startBad;
   logic                          w_accept;
   logic                          w_lastByte;
   logic                          w_lastWord;
   logic                          w_byteReady;
   logic                          w_wrEn;
   logic [XLEN-1:0]               w_addr;
   logic [INSTRUCTION_LENGTH-1:0] w_instr;
   logic                          w_cpuRst;
   logic                          w_busy;
   logic                          w_done;

   // A new request is only looked at while idle or after a finished load;
   // requests arriving mid-load are simply dropped.
   assign w_canStart  = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_lenTooBig = {16'd0, bus.load_len} > 32'(MAX_WORDS);
   assign w_startOk   = bus.start && w_canStart && !w_lenTooBig;
   assign w_startBad  = bus.start && w_canStart && w_lenTooBig;
   assign w_accept    = bus.byte_valid && w_byteReady;
   assign w_lastByte  = (r_byteCnt == CW'(BPI - 1));
   assign w_lastWord  = ((r_index + 16'd1) == r_len);

   // State register: the only place the FSM state changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. A zero-length load skips straight to the end of the
   // load (or to the trailer byte when the checksum is enabled).
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (w_startOk) begin
               if (bus.load_len != 16'd0) begin
                  w_nextState = S_RECV;
               end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  w_nextState = S_CHECK;
`else
                  w_nextState = S_DONE;
`endif
               end
            end
         end
         S_RECV: begin
            if (w_accept && w_lastByte) begin
               w_nextState = S_WRITE;
            end
         end
         S_WRITE: begin
            if (w_lastWord) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
               w_nextState = S_CHECK;
`else
               w_nextState = S_DONE;
`endif
            end else begin
               w_nextState = S_RECV;
            end
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (w_accept) begin
               w_nextState = S_DONE;
            end
         end
`endif
         default: w_nextState = S_IDLE;
      endcase
   end

   // Output decode from the state and datapath registers only, so no input
   // ever reaches an output combinationally. Address and data are forced to
   // zero outside the write cycle so the port idles at its reset values.
   always_comb begin
      w_byteReady = 1'b0;
      w_wrEn      = 1'b0;
      w_addr      = '0;
      w_instr     = '0;
      w_cpuRst    = 1'b1;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         S_RECV: begin
            w_byteReady = 1'b1;
            w_busy      = 1'b1;
         end
         S_WRITE: begin
            w_wrEn  = 1'b1;
            w_addr  = BASE_ADDR + XLEN'({r_index, 2'b00});
            w_instr = r_buf;
            w_busy  = 1'b1;
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         S_CHECK: begin
            w_byteReady = 1'b1;
            w_busy      = 1'b1;
         end
`endif
         S_DONE: begin
            w_cpuRst = 1'b0;
            w_done   = 1'b1;
         end
         default: begin
            w_cpuRst = 1'b1;
         end
      endcase
   end

   // Datapath: length/index bookkeeping, little-endian byte assembly,
   // running payload sum and the sticky error flags of the last request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len     <= '0;
         r_index   <= '0;
         r_byteCnt <= '0;
         r_buf     <= '0;
         r_lenErr  <= 1'b0;
         r_csErr   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         r_sum     <= '0;
`endif
      end else begin
         if (w_startOk) begin
            r_len     <= bus.load_len;
            r_index   <= '0;
            r_byteCnt <= '0;
            r_lenErr  <= 1'b0;
            r_csErr   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_sum     <= '0;
`endif
         end else if (w_startBad) begin
            r_lenErr <= 1'b1;
         end
         if ((r_state == S_RECV) && w_accept) begin
            r_buf[{r_byteCnt, 3'b000} +: 8] <= bus.byte_data;
            r_byteCnt <= w_lastByte ? '0 : r_byteCnt + CW'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_sum     <= r_sum + bus.byte_data;
`endif
         end
         if (r_state == S_WRITE) begin
            r_index <= r_index + 16'd1;
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         if ((r_state == S_CHECK) && w_accept) begin
            r_csErr <= (bus.byte_data != r_sum);
         end
`endif
      end
   end

   assign bus.byte_ready   = w_byteReady;
   assign bus.dbg_wr_en    = w_wrEn;
   assign bus.dbg_addr     = w_addr;
   assign bus.dbg_instr    = w_instr;
   assign bus.cpu_rst      = w_cpuRst;
   assign bus.busy         = w_busy;
   assign bus.done         = w_done;
   assign bus.len_err      = r_lenErr;
   assign bus.checksum_err = r_csErr;

endmodule
